// File: rtl/organ_note_scheduler.sv
// Purpose : resolves 14 organ keys into one note code (manual, lowest key wins) or plays a 16-entry song (auto).
// Latency : manual press to note = 2 sync + DEB_CYC debounce + 2 register stages; auto drop reaches MANUAL in 3 cycles.
// Backpres: none; outputs are registered levels plus a one-cycle beat_tick pulse, with no handshake.
//
// Ports:
//   clk_in     system clock (1 MHz nominal)
//   rst        asynchronous active-low reset
//   auto       1 = play the built-in song, 0 = follow keys (asynchronous level)
//   Key[13:0]  key vector, bit i = key i+1 pressed (asynchronous)
//   note       0 = rest, 1..7 = low do..si, 8..14 = middle do..si
//   note_on    1 while a non-rest note sounds
//   song_pos   current song ROM index in auto mode, 0 in manual mode
//   beat_tick  one-cycle pulse when an auto-mode note starts
module organ_note_scheduler #(
    parameter int DEB_CYC  = 5000,
    parameter int BEAT_CYC = 250000,
    parameter int GAP_CYC  = 20000,
    parameter int SONG_LEN = 16
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        auto,
    input  logic [13:0] Key,
    output logic [3:0]  note,
    output logic        note_on,
    output logic [3:0]  song_pos,
    output logic        beat_tick
);

    localparam int MAX_BD  = (BEAT_CYC > DEB_CYC) ? BEAT_CYC : DEB_CYC;
    localparam int CNT_MAX = (GAP_CYC > MAX_BD) ? GAP_CYC : MAX_BD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        AUTO_NOTE = 2'd1,
        AUTO_GAP  = 2'd2
    } state_t;

    state_t         state;
    logic           auto_s1, auto_s2, auto_d;
    logic [13:0]    key_s1, key_s2;
    logic [13:0]    cand, key_stable;
    logic [CW-1:0]  deb_cnt;
    logic [CW-1:0]  cnt;
    logic [3:0]     sel;
    logic [3:0]     pos_next;

    // Song ROM; rest entries (0) still occupy a full beat.
    function automatic logic [3:0] rom(input logic [3:0] p);
        case (p)
            4'd0, 4'd1, 4'd14:        rom = 4'd1;
            4'd2, 4'd3, 4'd6:         rom = 4'd5;
            4'd4, 4'd5:               rom = 4'd6;
            4'd8, 4'd9:               rom = 4'd4;
            4'd10, 4'd11:             rom = 4'd3;
            4'd12, 4'd13:             rom = 4'd2;
            default:                  rom = 4'd0;
        endcase
    endfunction

    // Two-flop synchronisers; auto_d keeps the previous synced level for rise detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
            auto_d  <= 1'b0;
            key_s1  <= '0;
            key_s2  <= '0;
        end else begin
            auto_s1 <= auto;
            auto_s2 <= auto_s1;
            auto_d  <= auto_s2;
            key_s1  <= Key;
            key_s2  <= key_s1;
        end
    end

    // Debouncer runs in every mode so the right note is ready on return to manual.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cand       <= '0;
            deb_cnt    <= '0;
            key_stable <= '0;
        end else if (key_s2 != cand) begin
            cand    <= key_s2;
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYC - 1)) begin
            key_stable <= cand;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Lowest-index key wins: scan from the top so the lowest set bit is written last.
    always_comb begin
        sel = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (key_stable[i]) sel = 4'(i + 1);
        end
    end

    assign pos_next = (song_pos == 4'(SONG_LEN - 1)) ? 4'd0 : song_pos + 4'd1;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= MANUAL;
            cnt       <= '0;
            note      <= 4'd0;
            note_on   <= 1'b0;
            song_pos  <= 4'd0;
            beat_tick <= 1'b0;
        end else begin
            beat_tick <= 1'b0;
            if (!auto_s2) begin
                // Leaving auto takes priority over any beat/gap expiry in the same cycle.
                state    <= MANUAL;
                cnt      <= '0;
                song_pos <= 4'd0;
                note     <= sel;
                note_on  <= (sel != 4'd0);
            end else begin
                case (state)
                    MANUAL: begin
                        if (!auto_d) begin
                            state     <= AUTO_NOTE;
                            cnt       <= '0;
                            song_pos  <= 4'd0;
                            beat_tick <= 1'b1;
                            note      <= rom(4'd0);
                            note_on   <= (rom(4'd0) != 4'd0);
                        end else begin
                            note    <= sel;
                            note_on <= (sel != 4'd0);
                        end
                    end
                    AUTO_NOTE: begin
                        if (cnt == CW'(BEAT_CYC - 1)) begin
                            state   <= AUTO_GAP;
                            cnt     <= '0;
                            note    <= 4'd0;
                            note_on <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    AUTO_GAP: begin
                        if (cnt == CW'(GAP_CYC - 1)) begin
                            state     <= AUTO_NOTE;
                            cnt       <= '0;
                            beat_tick <= 1'b1;
                            song_pos  <= pos_next;
                            note      <= rom(pos_next);
                            note_on   <= (rom(pos_next) != 4'd0);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= MANUAL;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_organ_note_scheduler.sv
// Purpose : self-checking bench for organ_note_scheduler (manual table, glitch, auto song, abort, reset).
// Latency : checks sampled on the falling clock edge after each stimulus window.
// Backpres: not applicable; stimulus is free-running.
module tb_organ_note_scheduler;

    localparam int DEB  = 4;
    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int LEN  = 16;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b1;
    logic        auto   = 1'b1;
    logic [13:0] Key    = 14'h3FFF;
    logic [3:0]  note;
    logic        note_on;
    logic [3:0]  song_pos;
    logic        beat_tick;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [13:0] key;
        int          hold;
        logic [3:0]  note;
        logic        on;
    } vec_t;

    typedef struct {
        logic [3:0] note;
        logic       on;
        logic [3:0] pos;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [3:0] song[16] = '{4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6, 4'd5, 4'd0,
                             4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};

    organ_note_scheduler #(
        .DEB_CYC (DEB),
        .BEAT_CYC(BEAT),
        .GAP_CYC (GAP),
        .SONG_LEN(LEN)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .auto     (auto),
        .Key      (Key),
        .note     (note),
        .note_on  (note_on),
        .song_pos (song_pos),
        .beat_tick(beat_tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (beat_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_vec(input int idx);
        exp_t e;
        e.note = vecs[idx].note;
        e.on   = vecs[idx].on;
        e.pos  = 4'd0;
        sb.push_back(e);
        Key = vecs[idx].key;
        repeat (vecs[idx].hold) @(negedge clk_in);
        e = sb.pop_front();
        chk($sformatf("manual[%0d] note", idx), 16'(note), 16'(e.note));
        chk($sformatf("manual[%0d] note_on", idx), 16'(note_on), 16'(e.on));
        chk($sformatf("manual[%0d] song_pos", idx), 16'(song_pos), 16'(e.pos));
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit   ok;
        exp_t e;

        vecs.push_back('{key: 14'h0010, hold: 20, note: 4'd5, on: 1'b1});
        vecs.push_back('{key: 14'h0000, hold: 20, note: 4'd0, on: 1'b0});
        vecs.push_back('{key: 14'h2004, hold: 20, note: 4'd3, on: 1'b1});
        for (int i = 0; i < 14; i++)
            vecs.push_back('{key: 14'(1 << i), hold: 20, note: 4'(i + 1), on: 1'b1});

        // Reset held with every key pressed and auto high: outputs stay quiet.
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("reset note", 16'(note), 16'd0);
            chk("reset note_on", 16'(note_on), 16'd0);
            chk("reset song_pos", 16'(song_pos), 16'd0);
            chk("reset beat_tick", 16'(beat_tick), 16'd0);
        end
        auto = 1'b0;
        Key  = 14'h0000;
        @(negedge clk_in);
        rst = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("idle note", 16'(note), 16'd0);

        // Manual single key, release, two-key priority.
        for (int i = 0; i < 3; i++) apply_vec(i);

        // A 2-cycle glitch on key 1 must never reach the output.
        Key = 14'h2005;
        repeat (2) @(negedge clk_in);
        Key = 14'h2004;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            if (i % 5 == 4) chk("glitch note", 16'(note), 16'd3);
        end

        // One-hot sweep of all 14 keys.
        for (int i = 3; i < vecs.size(); i++) apply_vec(i);

        // Auto mode: 18 beats, wrapping past pos 15; key 8 pressed meanwhile.
        for (int b = 0; b < 18; b++) begin
            e.note = song[b % LEN];
            e.on   = (song[b % LEN] != 4'd0);
            e.pos  = 4'(b % LEN);
            sb.push_back(e);
        end
        auto = 1'b1;
        Key  = 14'h0080;
        wait_tick(10, ok);
        chk("auto first tick", 16'(ok), 16'd1);
        for (int b = 0; b < 18; b++) begin
            e = sb.pop_front();
            chk($sformatf("beat[%0d] song_pos", b), 16'(song_pos), 16'(e.pos));
            chk($sformatf("beat[%0d] note", b), 16'(note), 16'(e.note));
            chk($sformatf("beat[%0d] note_on", b), 16'(note_on), 16'(e.on));
            for (int c = 1; c <= BEAT + GAP; c++) begin
                @(negedge clk_in);
                if (c < BEAT) begin
                    chk($sformatf("beat[%0d] hold", b), 16'({note, beat_tick}), 16'({e.note, 1'b0}));
                end else if (c < BEAT + GAP) begin
                    chk($sformatf("beat[%0d] gap", b), 16'({note, note_on}), 16'd0);
                end else begin
                    chk($sformatf("beat[%0d] next tick", b), 16'(beat_tick), 16'd1);
                end
            end
        end

        // Abort during pos 6 (note 5) with key 8 held: manual note 8 within 3 cycles.
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_in);
            if (beat_tick === 1'b1 && song_pos == 4'd6) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach pos 6", 16'(ok), 16'd1);
        repeat (2) @(negedge clk_in);
        auto = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("abort note", 16'(note), 16'd8);
        chk("abort note_on", 16'(note_on), 16'd1);
        chk("abort song_pos", 16'(song_pos), 16'd0);
        repeat (BEAT + GAP) @(negedge clk_in);
        chk("abort stays manual", 16'({note, beat_tick}), 16'({4'd8, 1'b0}));

        // A later auto rise restarts the song from pos 0.
        auto = 1'b1;
        wait_tick(10, ok);
        chk("restart tick", 16'(ok), 16'd1);
        chk("restart song_pos", 16'(song_pos), 16'd0);
        chk("restart note", 16'(note), 16'd1);

        // Asynchronous reset mid-note, then the next pass starts at pos 0.
        repeat (20) @(negedge clk_in);
        #2 rst = 1'b0;
        #1;
        chk("midreset note", 16'(note), 16'd0);
        chk("midreset note_on", 16'(note_on), 16'd0);
        chk("midreset song_pos", 16'(song_pos), 16'd0);
        @(negedge clk_in);
        rst = 1'b1;
        wait_tick(10, ok);
        chk("post-reset tick", 16'(ok), 16'd1);
        chk("post-reset song_pos", 16'(song_pos), 16'd0);
        chk("post-reset note", 16'(note), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
